// File: rtl/interpolator.sv
// rtl/interpolator.sv - per-channel FACTOR upsampler on a channel-interleaved stream (ZOH_EN selects zero-order hold)
//
// Each accepted input beat expands into FACTOR output beats with the same tuser.
// Default build: beat 0 carries the sample and beats 1..FACTOR-1 are zero (zero-stuffing).
// With ZOH_EN defined, beats 1..FACTOR-1 repeat the sample (zero-order hold).
// s_axis_tready depends combinationally on m_axis_tready, so the next burst starts with no bubble.
module interpolator #(
  parameter int DATA_W = 24,
  parameter int USER_W = 3,
  parameter int FACTOR = 5
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [USER_W-1:0] s_axis_tuser,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [USER_W-1:0] m_axis_tuser
);

  localparam int PH_W = (FACTOR > 1) ? $clog2(FACTOR) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(FACTOR - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [USER_W-1:0] user_q,  user_d;

  logic last_beat;
  logic out_xfer;
  logic in_xfer;

  assign last_beat = (state_q == EMIT) && (phase_q == PH_LAST);
  assign out_xfer  = m_axis_tvalid && m_axis_tready;
  assign in_xfer   = s_axis_tvalid && s_axis_tready;

  // State, phase and held sample registers; reset discards any burst in flight.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= IDLE;
      phase_q <= '0;
      data_q  <= '0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      user_q  <= user_d;
    end
  end

  // Next state: leave IDLE on any input, drop back only when the last beat leaves with no successor.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (last_beat && m_axis_tready && !s_axis_tvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase counter and sample capture; a new sample always restarts the burst at phase 0.
  always_comb begin
    phase_d = phase_q;
    data_d  = data_q;
    user_d  = user_q;
    if (out_xfer) begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
    if (in_xfer) begin
      phase_d = '0;
      data_d  = s_axis_tdata;
      user_d  = s_axis_tuser;
    end
  end

  // Handshake and output beat formation from the registered state.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    if (s_axis_aresetn) begin
      case (state_q)
        IDLE: begin
          s_axis_tready = 1'b1;
        end
        EMIT: begin
          m_axis_tvalid = 1'b1;
          m_axis_tuser  = user_q;
          s_axis_tready = last_beat && m_axis_tready;
`ifdef ZOH_EN
          m_axis_tdata  = data_q;
`else
          m_axis_tdata  = (phase_q == '0) ? data_q : '0;
`endif
        end
        default: begin
          s_axis_tready = 1'b0;
        end
      endcase
    end
  end

endmodule
